fc_rd_ctrl: RTL
===============

Name: fc_rd_ctrl

Overview:
- Operand fetch controller directly upstream of the fully-connected stage.
- On start, reads the data matrix and weight matrix from a single-port 32-bit word memory and presents them together with data_en/weight_en.
- Reads the bias vector when the FC stage raises bias_rq, holds bias_en until the FC stage reports result_valid, then pulses done.

Parameters:
- batch_size, 1, rows of data; must match the FC stage.
- feature_size, 3, columns of data and rows of weight.
- bias_size, 2, columns of weight and length of bias.
- addr_width, 16, memory word-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level; sampled only in IDLE.
- data_base  in  addr_width  word address of data[0][0]; data[b][f] at data_base + b*feature_size + f.
- weight_base  in  addr_width  word address of weight[0][0]; weight[f][c] at weight_base + f*bias_size + c.
- bias_base  in  addr_width  word address of bias[0]; bias[j] at bias_base + j.
- mem_rd  out  1  read strobe.
- mem_addr  out  addr_width  read address.
- mem_rdata  in  32  read data, valid exactly one cycle after the mem_rd cycle.
- data  out  batch_size*feature_size*32  packed [b][f].
- weight  out  feature_size*bias_size*32  packed [f][c].
- bias  out  bias_size*32  packed [j].
- data_en, weight_en  out  1 each  operands valid; always equal.
- bias_rq  in  1  one-cycle request from the FC stage.
- bias_en  out  1  bias valid.
- result_valid  in  1  FC result pulse.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky protocol error; cleared only by reset.

Behaviour:
- Reset: all outputs 0, all operand registers 0, state IDLE. Asserting reset mid-operation aborts immediately with no residual strobes.
- Definitions: ND = batch_size*feature_size, NW = feature_size*bias_size, N = ND+NW.
- States: IDLE, RD_DW, DRAIN, PRESENT, RD_B, DRAIN_B, HOLD, FIN.
- IDLE: start=1 at an edge moves to RD_DW and latches all three bases. start is ignored in all other states.
- RD_DW: issues N back-to-back reads in cycles 0..N-1 after the start edge, one per cycle, with no gaps.
  - Reads 0..ND-1 target the data addresses in row-major order; reads ND..N-1 target the weight addresses.
  - Each mem_rdata is captured into its slot one cycle after its read cycle.
- DRAIN: one cycle to capture the final word.
- PRESENT: data_en and weight_en are high from cycle N+1 and stay high until the cycle after bias_rq is sampled. data and weight stay stable throughout.
- bias_rq sampled in PRESENT moves to RD_B.
  - RD_B issues bias_size consecutive reads; DRAIN_B captures the last word.
  - bias_rq in any other non-IDLE state sets err and is otherwise ignored.
  - bias_rq in IDLE is ignored.
- HOLD: bias_en is high for the whole state; bias is stable.
  - result_valid sampled in HOLD moves to FIN.
  - result_valid outside HOLD sets err and is ignored.
- FIN: done=1 for one cycle, bias_en drops, then IDLE. data, weight and bias keep their values until the next capture.
- bias_rq and result_valid in the same cycle: only the input matching the current state acts; the other follows the err rule.
- Address arithmetic: modulo 2^addr_width, wrapping silently with no flag.
- mem_rd is 0 in every state except RD_DW and RD_B. mem_addr is 0 whenever mem_rd is 0.
- Minimum start-to-done latency with defaults: N+1 cycles to present, plus FC turnaround, plus bias_size+1 cycles to raise bias_en.

Test Plan:
- Defaults, data_base=0x10, weight_base=0x20, bias_base=0x30, mem[a]=a; pulse start -> mem_addr 0x10,0x11,0x12,0x20..0x25 on consecutive cycles. data_en/weight_en rise in cycle 10; data={0x10,0x11,0x12}, weight={0x20..0x25}.
- Same run; bias_rq pulse 3 cycles after data_en -> data_en drops the next cycle. Reads 0x30,0x31 follow; bias_en rises 3 cycles after the bias_rq edge with bias={0x30,0x31}. result_valid 5 cycles later -> done pulse 1 cycle, busy=0 afterwards.
- start held high through an entire transaction -> exactly one fetch sequence; a second sequence starts only after FIN returns to IDLE.
- bias_rq injected during RD_DW, and result_valid injected during PRESENT -> err=1 and stays 1; the sequence completes normally.
- data_base=0xFFFE with addr_width=16 -> addresses 0xFFFE,0xFFFF,0x0000 for the data reads; no err.
- rst_n low during RD_B -> all outputs 0 at once; after release with start=0 the block stays IDLE with no mem_rd.

Source files
------------

// File: rtl/fc_rd_ctrl.sv
// Operand fetch controller for the fully-connected stage: reads the data and weight
// matrices (and, on request, the bias vector) from a single-port word memory.
module fc_rd_ctrl #(
  parameter int batch_size   = 1,
  parameter int feature_size = 3,
  parameter int bias_size    = 2,
  parameter int addr_width   = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [addr_width-1:0]                data_base,
  input  logic [addr_width-1:0]                weight_base,
  input  logic [addr_width-1:0]                bias_base,
  output logic                                 mem_rd,
  output logic [addr_width-1:0]                mem_addr,
  input  logic [31:0]                          mem_rdata,
  output logic [batch_size*feature_size*32-1:0] data,
  output logic [feature_size*bias_size*32-1:0]  weight,
  output logic [bias_size*32-1:0]              bias,
  output logic                                 data_en,
  output logic                                 weight_en,
  input  logic                                 bias_rq,
  output logic                                 bias_en,
  input  logic                                 result_valid,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int ND    = batch_size * feature_size;
  localparam int NW    = feature_size * bias_size;
  localparam int N     = ND + NW;
  localparam int NS    = N + bias_size;
  localparam int CNT_W = (NS > 1) ? $clog2(NS) : 1;

  localparam logic [CNT_W-1:0] ND_C    = CNT_W'(ND);
  localparam logic [CNT_W-1:0] N_C     = CNT_W'(N);
  localparam logic [CNT_W-1:0] LAST_DW = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_B  = CNT_W'(bias_size - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_DW, S_DRAIN, S_PRESENT, S_RD_B, S_DRAIN_B, S_HOLD, S_FIN
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [addr_width-1:0] r_data_base;
  logic [addr_width-1:0] r_weight_base;
  logic [addr_width-1:0] r_bias_base;
  logic                  r_cap_vld;
  logic [CNT_W-1:0]      r_cap_idx;
  logic [31:0]           r_ops [NS];
  logic                  r_err;

  logic                  w_rd;
  logic [addr_width-1:0] w_addr;
  logic [CNT_W-1:0]      w_slot;
  logic                  w_err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_rd      = 1'b0;
    w_addr    = '0;
    w_slot    = '0;
    data_en   = 1'b0;
    bias_en   = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    w_err_set = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_RD_DW;
      end
      S_RD_DW: begin
        // Data and weight matrices are each contiguous, so the read index is the offset.
        w_rd   = 1'b1;
        w_slot = r_cnt;
        if (r_cnt < ND_C) w_addr = r_data_base + addr_width'(r_cnt);
        else              w_addr = r_weight_base + addr_width'(r_cnt - ND_C);
        if (r_cnt == LAST_DW) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_PRESENT;
      S_PRESENT: begin
        data_en = 1'b1;
        if (bias_rq) w_next = S_RD_B;
      end
      S_RD_B: begin
        w_rd   = 1'b1;
        w_slot = N_C + r_cnt;
        w_addr = r_bias_base + addr_width'(r_cnt);
        if (r_cnt == LAST_B) w_next = S_DRAIN_B;
      end
      S_DRAIN_B: w_next = S_HOLD;
      S_HOLD: begin
        bias_en = 1'b1;
        if (result_valid) w_next = S_FIN;
      end
      S_FIN: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
    endcase
    if (bias_rq && r_state != S_IDLE && r_state != S_PRESENT) w_err_set = 1'b1;
    if (result_valid && r_state != S_HOLD)                    w_err_set = 1'b1;
  end

  assign mem_rd    = w_rd;
  assign mem_addr  = w_addr;
  assign weight_en = data_en;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_data_base   <= '0;
      r_weight_base <= '0;
      r_bias_base   <= '0;
      r_err         <= 1'b0;
    end else begin
      r_cnt <= (w_rd && w_next == r_state) ? r_cnt + CNT_W'(1) : '0;
      if (r_state == S_IDLE && start) begin
        r_data_base   <= data_base;
        r_weight_base <= weight_base;
        r_bias_base   <= bias_base;
      end
      r_err <= r_err | w_err_set;
    end
  end

  // Read data arrives one cycle after its strobe; the slot index travels with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_vld <= 1'b0;
      r_cap_idx <= '0;
      for (int k = 0; k < NS; k++) r_ops[k] <= '0;
    end else begin
      r_cap_vld <= w_rd;
      r_cap_idx <= w_slot;
      if (r_cap_vld) r_ops[r_cap_idx] <= mem_rdata;
    end
  end

  // Element k of each packed output occupies bits [k*32 +: 32], k in row-major order.
  for (genvar k = 0; k < ND; k++) begin : g_data
    assign data[k*32 +: 32] = r_ops[k];
  end
  for (genvar k = 0; k < NW; k++) begin : g_weight
    assign weight[k*32 +: 32] = r_ops[ND + k];
  end
  for (genvar k = 0; k < bias_size; k++) begin : g_bias
    assign bias[k*32 +: 32] = r_ops[N + k];
  end

endmodule
